downcounter_dig2: RTL and testbench
===================================

Name: downcounter_dig2

Overview:
- Two-digit BCD countdown timer: tens and ones digits count down toward 00 on an external enable tick.
- Complements the up-counting digit blocks; used as the countdown/timer path in the lab timer display datapath.
- Driven by the 1 Hz (or scan-rate) enable pulse from the frequency divider; feeds the BCD-to-7-segment decoders.
- Contains a 4-state run-control FSM and a one-cycle expire pulse.

Parameters:
- BCD_BIT_WIDTH, 4, width of each BCD digit.
- ONES_MAX, 9, value loaded into ones on borrow.
- TENS_MAX, 5, largest legal tens value; used for clamping (59 max for seconds).
- RST_TENS, 3, tens value after reset.
- RST_ONES, 0, ones value after reset.

Ports:
- clk  input  1  system clock; all state updates on posedge.
- rst_n  input  1  asynchronous active-low reset.
- tick  input  1  one-cycle count enable; decrement happens only when sampled high in RUN.
- start_stop  input  1  one-cycle pulse (already debounced/one-pulsed); toggles run/pause.
- load_def  input  1  synchronous load of def_tens/def_ones; forces IDLE.
- def_tens  input  BCD_BIT_WIDTH  tens load value.
- def_ones  input  BCD_BIT_WIDTH  ones load value.
- tens  output  BCD_BIT_WIDTH  registered tens digit.
- ones  output  BCD_BIT_WIDTH  registered ones digit.
- state  output  2  registered FSM state: IDLE=00, RUN=01, PAUSE=10, DONE=11.
- expire  output  1  registered; high exactly one cycle after the 01→00 transition.
- done  output  1  combinational, equals (state==DONE).

Behaviour:
- Reset (async, rst_n=0): tens=RST_TENS, ones=RST_ONES, state=IDLE, expire=0.
- All other updates occur on posedge clk.
- Priority: rst_n > load_def > start_stop > tick.
- load_def=1 (any state):
  - ones = min(def_ones, ONES_MAX); tens = min(def_tens, TENS_MAX).
  - state=IDLE, expire=0.
  - start_stop and tick are ignored that cycle.
- IDLE:
  - start_stop: go to RUN if {tens,ones}!=00, otherwise go to DONE (expire stays 0).
  - tick ignored.
- RUN:
  - On tick, decrement:
    - ones!=0: ones-1.
    - ones==0: ones=ONES_MAX, tens-1.
    - Value 01 with tick: becomes 00, state→DONE, expire=1 next cycle.
  - start_stop in same cycle as tick: the decrement is applied and state→PAUSE. If that decrement reaches 00, DONE wins over PAUSE.
- PAUSE:
  - Digits hold.
  - start_stop: go to RUN.
  - tick in the same cycle is not counted.
- DONE:
  - Digits hold at 00.
  - start_stop and tick ignored.
  - Exit only via load_def or reset.
- expire:
  - Registered, high for exactly one cycle, then 0.
  - Never asserted by load_def or by an IDLE→DONE transition.
- Latency: tick sampled at edge N produces the new digits visible after edge N; no pipelining.
- Arithmetic:
  - Digits never take values >9.
  - tens never decrements below 0, because 00 is only reachable through the DONE transition.
- Reset mid-run: immediate return to reset values; no expire pulse.

Optional Feature:
- Macro: DOWNCOUNTER_AUTORELOAD_EN.
- Defined:
  - In RUN, tick at 01 reloads the last values latched by load_def (clamped), or RST_TENS/RST_ONES if no load_def has occurred since reset.
  - State stays RUN; expire still pulses one cycle.
  - DONE is reachable only from IDLE with value 00.
- Not defined:
  - Behaviour as above; the count stops in DONE.
  - No shadow reload registers are synthesized.

Test Plan:
- Reset then idle: rst_n low then high → tens=3, ones=0, state=00, expire=0. Ten ticks → no change.
- Full countdown with borrow:
  - load_def with 1,2 → 12.
  - start_stop, then ticks → 11, 10, 09 (ones borrow to 9, tens=0).
  - Ticks continue to 01, then 00: state=11, one-cycle expire. Further ticks → 00 held.
- Pause/resume with simultaneous events:
  - At 25 in RUN, tick+start_stop in same cycle → 24, PAUSE.
  - Three ticks → 24 held.
  - start_stop+tick in same cycle → RUN, still 24. Next tick → 23.
- Load clamp and zero start:
  - load_def with 7,12 → 59.
  - load_def with 0,0 then start_stop → DONE, expire never asserted.
- Priority and async reset:
  - In RUN at 40, load_def+start_stop+tick in same cycle → 40 from defaults, IDLE.
  - rst_n asserted mid-cycle while RUN → outputs reset immediately, without waiting for clk.
- Autoreload (DOWNCOUNTER_AUTORELOAD_EN defined):
  - load 0,3 and run.
  - Tick at 01 → 03, state stays RUN, expire pulses once per wrap over two wraps.

Source files
------------

// File: rtl/downcounter_dig2.sv
// -----------------------------------------------------------------------------
// downcounter_dig2 -- two-digit BCD countdown timer with run-control FSM.
//
// The tens and ones digits count down toward 00 on each enable tick while the
// FSM is in RUN. Reaching 00 from RUN raises a one-cycle registered expire
// pulse and parks the FSM in DONE. The only ways out of DONE are load_def and
// reset.
//
// Optional feature (macro DOWNCOUNTER_AUTORELOAD_EN):
//   When the macro is defined, a tick at 01 in RUN reloads the value most
//   recently captured by load_def. If no load_def has happened since reset,
//   the reset value is reloaded instead. The FSM stays in RUN and expire still
//   pulses. When the macro is undefined, the count stops in DONE and no
//   shadow registers exist.
//
// Ports:
//   clk         system clock, posedge active
//   rst_n       asynchronous active-low reset
//   tick        one-cycle count enable (honoured only in RUN)
//   start_stop  one-cycle pulse that toggles run/pause
//   load_def    synchronous load of def_tens/def_ones (clamped), forces IDLE
//   def_tens    tens load value
//   def_ones    ones load value
//   tens, ones  registered BCD digits
//   state       registered FSM state (IDLE=00, RUN=01, PAUSE=10, DONE=11)
//   expire      registered one-cycle pulse after the 01 -> 00 step
//   done        combinational, high while state == DONE
// -----------------------------------------------------------------------------
module downcounter_dig2 #(
   parameter int unsigned BCD_BIT_WIDTH = 4,
   parameter int unsigned ONES_MAX      = 9,
   parameter int unsigned TENS_MAX      = 5,
   parameter int unsigned RST_TENS      = 3,
   parameter int unsigned RST_ONES      = 0
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     tick,
   input  logic                     start_stop,
   input  logic                     load_def,
   input  logic [BCD_BIT_WIDTH-1:0] def_tens,
   input  logic [BCD_BIT_WIDTH-1:0] def_ones,
   output logic [BCD_BIT_WIDTH-1:0] tens,
   output logic [BCD_BIT_WIDTH-1:0] ones,
   output logic [1:0]               state,
   output logic                     expire,
   output logic                     done
);

   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      RUN   = 2'b01,
      PAUSE = 2'b10,
      DONE  = 2'b11
   } state_t;

   localparam logic [BCD_BIT_WIDTH-1:0] ONES_MAX_V = BCD_BIT_WIDTH'(ONES_MAX);
   localparam logic [BCD_BIT_WIDTH-1:0] TENS_MAX_V = BCD_BIT_WIDTH'(TENS_MAX);
   localparam logic [BCD_BIT_WIDTH-1:0] RST_TENS_V = BCD_BIT_WIDTH'(RST_TENS);
   localparam logic [BCD_BIT_WIDTH-1:0] RST_ONES_V = BCD_BIT_WIDTH'(RST_ONES);
   localparam logic [BCD_BIT_WIDTH-1:0] ZERO_V     = '0;
   localparam logic [BCD_BIT_WIDTH-1:0] ONE_V      = BCD_BIT_WIDTH'(1);

   state_t                     state_q, state_d;
   logic [BCD_BIT_WIDTH-1:0]   tens_q, tens_d;
   logic [BCD_BIT_WIDTH-1:0]   ones_q, ones_d;
   logic                       expire_q, expire_d;

   logic [BCD_BIT_WIDTH-1:0]   load_tens, load_ones;
   logic                       at_one;
   logic                       at_zero;

   // Out-of-range load values saturate, so a digit can never hold a value
   // above 9 and tens stays within the display range (59 max for seconds).
   assign load_tens = (def_tens > TENS_MAX_V) ? TENS_MAX_V : def_tens;
   assign load_ones = (def_ones > ONES_MAX_V) ? ONES_MAX_V : def_ones;

   assign at_one  = (tens_q == ZERO_V) && (ones_q == ONE_V);
   assign at_zero = (tens_q == ZERO_V) && (ones_q == ZERO_V);

`ifdef DOWNCOUNTER_AUTORELOAD_EN
   logic [BCD_BIT_WIDTH-1:0] shadow_tens_q, shadow_ones_q;

   // The shadow registers hold the last clamped load. They start at the
   // reset value so a wrap before any load_def returns to the reset count.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         shadow_tens_q <= RST_TENS_V;
         shadow_ones_q <= RST_ONES_V;
      end else if (load_def) begin
         shadow_tens_q <= load_tens;
         shadow_ones_q <= load_ones;
      end
   end
`endif

   // Next-state and next-digit logic. Priority is load_def, then start_stop,
   // then tick. start_stop and tick are only meaningful in some states.
   always_comb begin
      // NOTE: every output of this block gets a default first, so no path
      // through the case statement can leave a signal unassigned and infer
      // a latch.
      state_d  = state_q;
      tens_d   = tens_q;
      ones_d   = ones_q;
      expire_d = 1'b0;

      if (load_def) begin
         tens_d  = load_tens;
         ones_d  = load_ones;
         state_d = IDLE;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (start_stop) begin
                  // A zero start goes straight to DONE, with no expire.
                  state_d = at_zero ? DONE : RUN;
               end
            end

            RUN: begin
               if (tick) begin
                  if (at_one) begin
`ifdef DOWNCOUNTER_AUTORELOAD_EN
                     tens_d   = shadow_tens_q;
                     ones_d   = shadow_ones_q;
                     expire_d = 1'b1;
                     state_d  = start_stop ? PAUSE : RUN;
`else
                     // Reaching 00 has priority over a simultaneous pause.
                     ones_d   = ZERO_V;
                     expire_d = 1'b1;
                     state_d  = DONE;
`endif
                  end else begin
                     if (ones_q == ZERO_V) begin
                        ones_d = ONES_MAX_V;
                        tens_d = tens_q - ONE_V;
                     end else begin
                        ones_d = ones_q - ONE_V;
                     end
                     if (start_stop) begin
                        state_d = PAUSE;
                     end
                  end
               end else if (start_stop) begin
                  state_d = PAUSE;
               end
            end

            PAUSE: begin
               // A tick in the resume cycle is not counted.
               if (start_stop) begin
                  state_d = RUN;
               end
            end

            DONE: begin
               // Hold until load_def or reset.
            end

            default: begin
               state_d = IDLE;
            end
         endcase
      end
   end

   // NOTE: state registers use non-blocking assignments, so every register
   // samples the values from before this clock edge, regardless of the order
   // in which the simulator evaluates the always blocks.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         tens_q   <= RST_TENS_V;
         ones_q   <= RST_ONES_V;
         expire_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         tens_q   <= tens_d;
         ones_q   <= ones_d;
         expire_q <= expire_d;
      end
   end

   assign tens   = tens_q;
   assign ones   = ones_q;
   assign state  = state_q;
   assign expire = expire_q;
   assign done   = (state_q == DONE);

endmodule

// File: tb/tb_downcounter_dig2.sv
// -----------------------------------------------------------------------------
// tb_downcounter_dig2 -- scoreboard bench for downcounter_dig2.
//
// The driver applies one set of inputs per cycle on the falling edge. It then
// advances a reference model that tracks the count as a plain integer
// (0..59), and pushes the expected outputs into a queue. A separate monitor
// pops one entry 1 ns after each rising edge and compares it against the DUT.
// Asynchronous reset is checked directly, between clock edges.
// -----------------------------------------------------------------------------
module tb_downcounter_dig2;

   logic       clk;
   logic       rst_n;
   logic       tick;
   logic       start_stop;
   logic       load_def;
   logic [3:0] def_tens;
   logic [3:0] def_ones;
   logic [3:0] tens;
   logic [3:0] ones;
   logic [1:0] state;
   logic       expire;
   logic       done;

   downcounter_dig2 dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .tick       (tick),
      .start_stop (start_stop),
      .load_def   (load_def),
      .def_tens   (def_tens),
      .def_ones   (def_ones),
      .tens       (tens),
      .ones       (ones),
      .state      (state),
      .expire     (expire),
      .done       (done)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // ---------------- reference model (count kept as an integer) -----------
   localparam int M_IDLE = 0, M_RUN = 1, M_PAUSE = 2, M_DONE = 3;

   int m_cnt;
   int m_state;
   int m_shadow;
   bit m_exp;

   int n_checks = 0;
   int n_errors = 0;

   logic [11:0] exp_q[$];

   function automatic logic [11:0] model_out();
      return {4'(m_cnt / 10), 4'(m_cnt % 10), 2'(m_state), m_exp, (m_state == M_DONE)};
   endfunction

   task automatic model_reset();
      m_cnt    = 30;
      m_shadow = 30;
      m_state  = M_IDLE;
      m_exp    = 1'b0;
   endtask

   task automatic model_step(input bit t, input bit s, input bit l, input int dt, input int d1);
      m_exp = 1'b0;
      if (l) begin
         m_cnt    = ((dt > 5) ? 5 : dt) * 10 + ((d1 > 9) ? 9 : d1);
         m_shadow = m_cnt;
         m_state  = M_IDLE;
      end else begin
         case (m_state)
            M_IDLE:  if (s) m_state = (m_cnt != 0) ? M_RUN : M_DONE;
            M_RUN: begin
               if (t) begin
                  m_cnt = m_cnt - 1;
                  if (m_cnt == 0) begin
                     m_exp = 1'b1;
`ifdef DOWNCOUNTER_AUTORELOAD_EN
                     m_cnt   = m_shadow;
                     m_state = s ? M_PAUSE : M_RUN;
`else
                     m_state = M_DONE;
`endif
                  end else if (s) begin
                     m_state = M_PAUSE;
                  end
               end else if (s) begin
                  m_state = M_PAUSE;
               end
            end
            M_PAUSE: if (s) m_state = M_RUN;
            default: ;
         endcase
      end
   endtask

   // ---------------- checking ----------------------------------------------
   task automatic check(input string name, input logic [11:0] act, input logic [11:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got tens=%0d ones=%0d state=%0d expire=%0b done=%0b, want tens=%0d ones=%0d state=%0d expire=%0b done=%0b (t=%0t)",
                  name, act[11:8], act[7:4], act[3:2], act[1], act[0],
                  exp[11:8], exp[7:4], exp[3:2], exp[1], exp[0], $time);
      end
   endtask

   // Monitor: each rising edge presents one new output word.
   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() > 0) begin
            check("cycle", {tens, ones, state, expire, done}, exp_q.pop_front());
         end
      end
   end

   // ---------------- stimulus ----------------------------------------------
   task automatic step(input bit t, input bit s, input bit l, input int dt = 0, input int d1 = 0);
      @(negedge clk);
      tick       = t;
      start_stop = s;
      load_def   = l;
      def_tens   = 4'(dt);
      def_ones   = 4'(d1);
      model_step(t, s, l, dt, d1);
      exp_q.push_back(model_out());
   endtask

   task automatic ticks(input int n);
      repeat (n) step(1'b1, 1'b0, 1'b0);
   endtask

   // Asserts reset between clock edges, after the monitor has consumed the
   // last pending entry, and checks that the outputs change without a clock.
   task automatic async_reset(input string name);
      @(posedge clk);
      #3;
      tick       = 1'b0;
      start_stop = 1'b0;
      load_def   = 1'b0;
      rst_n      = 1'b0;
      model_reset();
      #1;
      check(name, {tens, ones, state, expire, done}, model_out());
      @(posedge clk);
      #1;
      check({name, "_held"}, {tens, ones, state, expire, done}, model_out());
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      rst_n      = 1'b1;
      tick       = 1'b0;
      start_stop = 1'b0;
      load_def   = 1'b0;
      def_tens   = '0;
      def_ones   = '0;
      #2;
      rst_n = 1'b0;
      model_reset();
      #1;
      check("reset", {tens, ones, state, expire, done}, model_out());
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;

      // Idle ignores ticks.
      ticks(10);

      // Full countdown with borrow from 12, then hold in DONE.
      step(0, 0, 1, 1, 2);
      step(0, 1, 0);
      ticks(12);
      ticks(3);
      step(0, 1, 0);

      // Pause/resume with simultaneous events.
      step(0, 0, 1, 2, 6);
      step(0, 1, 0);
      ticks(1);
      step(1, 1, 0);
      ticks(3);
      step(1, 1, 0);
      ticks(1);

      // Load clamp, then a zero start that goes to DONE without expire.
      step(0, 0, 1, 7, 12);
      step(0, 0, 1, 0, 0);
      step(0, 1, 0);
      ticks(2);

      // Priority: load_def wins over start_stop and tick while in RUN.
      step(0, 0, 1, 4, 0);
      step(0, 1, 0);
      step(1, 1, 1, 4, 0);
      step(0, 0, 0);

      // Asynchronous reset mid-run.
      step(0, 0, 1, 1, 5);
      step(0, 1, 0);
      ticks(2);
      async_reset("async_reset");
      ticks(2);

`ifdef DOWNCOUNTER_AUTORELOAD_EN
      // Two wraps from 01 back to 03, staying in RUN.
      step(0, 0, 1, 0, 3);
      step(0, 1, 0);
      ticks(7);
`endif

      // Randomized traffic.
      for (int i = 0; i < 1500; i++) begin
         step(1'($urandom_range(0, 1)),
              ($urandom_range(0, 7) == 0),
              ($urandom_range(0, 19) == 0),
              int'($urandom_range(0, 15)),
              int'($urandom_range(0, 15)));
      end

      async_reset("async_reset_rand");

      // Drain the scoreboard, with a bounded wait.
      step(0, 0, 0);
      repeat (3) @(posedge clk);
      #2;
      n_checks++;
      if (exp_q.size() != 0) begin
         n_errors++;
         $display("FAIL drain: %0d entries left, want 0", exp_q.size());
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
